// File: rtl/iob_fsm_initiator_pkg.sv
// iob_fsm_initiator_pkg: shared state encoding and timer sizing for the IOb initiator
package iob_fsm_initiator_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        RSP    = 2'd3
    } state_t;

    function automatic int timer_w(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/iob_fsm_initiator_if.sv
// iob_fsm_initiator_if: sequencer command/response port plus IOb request/response bus
// master: the initiator (drives cmd_ready, rsp_*, iob_avalid/addr/wdata/wstrb)
// slave : sequencer and peripheral side (drives cmd_*, iob_ready, iob_rvalid/rdata)
interface iob_fsm_initiator_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic [ADDR_W-1:0]     cmd_addr_i;
    logic [DATA_W-1:0]     cmd_wdata_i;
    logic [DATA_W/8-1:0]   cmd_wstrb_i;
    logic                  rsp_valid_o;
    logic [DATA_W-1:0]     rsp_rdata_o;
    logic                  rsp_err_o;
    logic                  iob_avalid_o;
    logic [ADDR_W-1:0]     iob_addr_o;
    logic [DATA_W-1:0]     iob_wdata_o;
    logic [DATA_W/8-1:0]   iob_wstrb_o;
    logic                  iob_rvalid_i;
    logic [DATA_W-1:0]     iob_rdata_i;
    logic                  iob_ready_i;

    modport master (
        input  cmd_valid_i, cmd_addr_i, cmd_wdata_i, cmd_wstrb_i,
        input  iob_rvalid_i, iob_rdata_i, iob_ready_i,
        output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output iob_avalid_o, iob_addr_o, iob_wdata_o, iob_wstrb_o
    );

    modport slave (
        output cmd_valid_i, cmd_addr_i, cmd_wdata_i, cmd_wstrb_i,
        output iob_rvalid_i, iob_rdata_i, iob_ready_i,
        input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  iob_avalid_o, iob_addr_o, iob_wdata_o, iob_wstrb_o
    );
endinterface

// File: rtl/iob_fsm_init_timer.sv
// iob_fsm_init_timer: transaction timer with clear/enable, flags the TIMEOUT-th counted cycle
// Ports: clk_i, arst_n_i (async active-low), cke_i (freeze), clr_i, en_i, expire_o
module iob_fsm_init_timer
    import iob_fsm_initiator_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic arst_n_i,
    input  logic cke_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);
    localparam int W = timer_w(TIMEOUT);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk_i or negedge arst_n_i)
        if (!arst_n_i) cnt_q <= '0;
        else if (cke_i) cnt_q <= cnt_d;

    // the counting cycle that would bring the count to TIMEOUT is the last one allowed
    assign expire_o = en_i & (cnt_q == W'(TIMEOUT - 1));
endmodule

// File: rtl/iob_fsm_initiator.sv
// iob_fsm_initiator: IOb manager issuing one sequencer command at a time with bounded timeout
// Ports: clk_i, arst_n_i (async active-low), cke_i (low freezes everything),
//        bus (master modport: cmd valid/ready, one-cycle rsp strobe, IOb request/response)
module iob_fsm_initiator
    import iob_fsm_initiator_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic arst_n_i,
    input  logic cke_i,
    iob_fsm_initiator_if.master bus
);
    localparam int STRB_W = DATA_W / 8;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                drain_q, drain_d;
    logic                cmd_rdy, accept, expire;

    // a timed-out read may still return data later; block new commands until it is swallowed
    assign cmd_rdy = (state_q == IDLE) & ~drain_q;
    assign accept  = bus.cmd_valid_i & cmd_rdy;

    iob_fsm_init_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .cke_i    (cke_i),
        .clr_i    (accept),
        .en_i     ((state_q == REQ) | (state_q == WAIT_R)),
        .expire_o (expire)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        drain_d = drain_q & ~bus.iob_rvalid_i;
        case (state_q)
            IDLE:
                if (accept) begin
                    state_d = REQ;
                    addr_d  = bus.cmd_addr_i;
                    wdata_d = bus.cmd_wdata_i;
                    wstrb_d = bus.cmd_wstrb_i;
                end
            REQ:
                // completion takes priority over a simultaneous expiry
                if (bus.iob_ready_i) begin
                    state_d = |wstrb_q ? RSP : WAIT_R;
                    err_d   = 1'b0;
                    rdata_d = '0;
                end else if (expire) begin
                    state_d = RSP;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            WAIT_R:
                if (bus.iob_rvalid_i) begin
                    state_d = RSP;
                    err_d   = 1'b0;
                    rdata_d = bus.iob_rdata_i;
                end else if (expire) begin
                    state_d = RSP;
                    err_d   = 1'b1;
                    rdata_d = '0;
                    drain_d = 1'b1;
                end
            RSP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i)
        if (!arst_n_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            drain_q <= 1'b0;
        end else if (cke_i) begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            drain_q <= drain_d;
        end

    assign bus.cmd_ready_o  = cmd_rdy;
    assign bus.rsp_valid_o  = state_q == RSP;
    assign bus.rsp_rdata_o  = rdata_q;
    assign bus.rsp_err_o    = err_q;
    assign bus.iob_avalid_o = state_q == REQ;
    assign bus.iob_addr_o   = addr_q;
    assign bus.iob_wdata_o  = wdata_q;
    assign bus.iob_wstrb_o  = wstrb_q;
endmodule
